// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch/decode boundary of the pipeline.
// Holds the canonical fetch entry layout and the NOP used when decode has nothing.
package pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side and the Execute redirect.
// master is the pipeline around the buffer; slave is the buffer itself.
interface if_id_buffer_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  valid_f;
    logic [DATA_WIDTH-1:0] pcF;
    logic [DATA_WIDTH-1:0] pc_plus4F;
    logic [DATA_WIDTH-1:0] instrF;
    logic                  ready_f;

    logic                  flushE;

    logic                  ready_d;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] pcD;
    logic [DATA_WIDTH-1:0] pc_plus4D;
    logic [DATA_WIDTH-1:0] instrD;

    modport master (
        output valid_f, pcF, pc_plus4F, instrF, flushE, ready_d,
        input  ready_f, valid_d, pcD, pc_plus4D, instrD
    );

    modport slave (
        input  valid_f, pcF, pc_plus4F, instrF, flushE, ready_d,
        output ready_f, valid_d, pcD, pc_plus4D, instrD
    );

endinterface

// File: rtl/fb_storage.sv
// Entry array for the fetch buffer: one synchronous write port, one asynchronous read port.
// Pointer and occupancy bookkeeping live in the parent; this block only stores.
module fb_storage
    import pipe_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);

    entry_t mem [DEPTH];

    // NOTE: no reset on the array; the parent gates every read with its occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID elastic buffer: a small FIFO between fetch and decode with flush, one-cycle
// push-to-head latency and a NOP presented to decode whenever the buffer is empty.
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic           clk,
    input  logic           rst,
    if_id_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(NOP);

    // Same layout as fetch_entry_t, sized to this instance's DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    entry_t                wr_entry;
    entry_t                rd_entry;
    logic [DATA_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_pc_plus4;

    // Handshake flags come straight from the count register, so ready_f never
    // depends combinationally on anything decode drives.
    assign bus.ready_f = (count < DEPTH_CNT);
    assign bus.valid_d = (count != '0);

    assign push = bus.valid_f && bus.ready_f && !bus.flushE;
    assign pop  = bus.valid_d && bus.ready_d && !bus.flushE;

    assign wr_entry = '{pc: bus.pcF, pc_plus4: bus.pc_plus4F, instr: bus.instrF};

    fb_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flushE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember what decode last saw so pcD/pc_plus4D stay put once the buffer drains.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_pc       <= '0;
            hold_pc_plus4 <= '0;
        end else if (bus.valid_d) begin
            hold_pc       <= rd_entry.pc;
            hold_pc_plus4 <= rd_entry.pc_plus4;
        end
    end

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        bus.pcD       = hold_pc;
        bus.pc_plus4D = hold_pc_plus4;
        bus.instrD    = NOP_WORD;
        if (bus.valid_d) begin
            bus.pcD       = rd_entry.pc;
            bus.pc_plus4D = rd_entry.pc_plus4;
            bus.instrD    = rd_entry.instr;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=2): fill/overflow, full-with-pop, streaming,
// flush, mid-run reset and pointer wrap, each with hand-computed expectations.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    if_id_buffer_if #(.DATA_WIDTH(32)) bus ();

    if_id_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hABC0_0000 | pc;
    endfunction

    function automatic logic [96:0] head_of(input logic [31:0] pc);
        return {1'b1, pc, pc + 32'd4, instr_of(pc)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rd, input logic fl);
        bus.valid_f   = v;
        bus.pcF       = pc;
        bus.pc_plus4F = pc + 32'd4;
        bus.instrF    = instr_of(pc);
        bus.ready_d   = rd;
        bus.flushE    = fl;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        checks++;
        if ({bus.valid_d, bus.ready_f} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags: got valid_d/ready_f=%b expected 01", {bus.valid_d, bus.ready_f});
        end
        checks++;
        if ({bus.pcD, bus.pc_plus4D, bus.instrD} !== {32'h0, 32'h0, NOP}) begin
            errors++;
            $display("FAIL reset_head: got %h expected %h", {bus.pcD, bus.pc_plus4D, bus.instrD},
                     {32'h0, 32'h0, NOP});
        end
    endtask

    task automatic test_fill_overflow();
        drive(1'b1, 32'h00, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !== head_of(32'h00)) begin
            errors++;
            $display("FAIL fill_first_latency: got %h expected %h",
                     {bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD}, head_of(32'h00));
        end
        checks++;
        if (bus.ready_f !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_one: got %b expected 1", bus.ready_f);
        end
        drive(1'b1, 32'h04, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.ready_f !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_full: got %b expected 0", bus.ready_f);
        end
        drive(1'b1, 32'h08, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D} !== {2'b01, 32'h00, 32'h04}) begin
            errors++;
            $display("FAIL fill_head_held: got %h expected %h", {bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D},
                     {2'b01, 32'h00, 32'h04});
        end
    endtask

    task automatic test_full_pop_reject();
        drive(1'b1, 32'h08, 1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !== head_of(32'h04)) begin
            errors++;
            $display("FAIL fullpop_head: got %h expected %h",
                     {bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD}, head_of(32'h04));
        end
        checks++;
        if (bus.ready_f !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_ready: got %b expected 1", bus.ready_f);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !== {1'b0, 32'h04, 32'h08, NOP}) begin
            errors++;
            $display("FAIL fullpop_empty_hold: got %h expected %h",
                     {bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD}, {1'b0, 32'h04, 32'h08, NOP});
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            checks++;
            if ({bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !==
                {1'b1, head_of(32'h10 + 32'(4 * i))}) begin
                errors++;
                $display("FAIL stream_%0d: got %h expected %h", i,
                         {bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD},
                         {1'b1, head_of(32'h10 + 32'(4 * i))});
            end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.instrD} !== {1'b0, NOP}) begin
            errors++;
            $display("FAIL stream_drain: got %h expected %h", {bus.valid_d, bus.instrD}, {1'b0, NOP});
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        tick();
        checks++;
        if ({bus.valid_d, bus.ready_f, bus.pcD, bus.instrD} !== {2'b01, 32'h20, NOP}) begin
            errors++;
            $display("FAIL flush_full: got %h expected %h", {bus.valid_d, bus.ready_f, bus.pcD, bus.instrD},
                     {2'b01, 32'h20, NOP});
        end
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !== head_of(32'h80)) begin
            errors++;
            $display("FAIL flush_refill: got %h expected %h",
                     {bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD}, head_of(32'h80));
        end
        drive(1'b1, 32'h90, 1'b0, 1'b1);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD, bus.instrD} !== {1'b0, 32'h80, NOP}) begin
            errors++;
            $display("FAIL flush_incoming: got %h expected %h", {bus.valid_d, bus.pcD, bus.instrD},
                     {1'b0, 32'h80, NOP});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.valid_d !== 1'b0) begin
            errors++;
            $display("FAIL flush_stays_empty: got %b expected 0", bus.valid_d);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'hA0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hA4, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'hA8, 1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.ready_f, bus.pcD, bus.pc_plus4D, bus.instrD} !==
            {2'b01, 32'h0, 32'h0, NOP}) begin
            errors++;
            $display("FAIL midreset_state: got %h expected %h",
                     {bus.valid_d, bus.ready_f, bus.pcD, bus.pc_plus4D, bus.instrD}, {2'b01, 32'h0, 32'h0, NOP});
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.valid_d, bus.pcD} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_nothing_kept: got %h expected %h", {bus.valid_d, bus.pcD}, {1'b0, 32'h0});
        end
    endtask

    task automatic test_wrap();
        // Leave the write pointer odd first so the alternating run crosses the wrap mid-sequence.
        drive(1'b1, 32'hF0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
            checks++;
            if ({bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD} !==
                {1'b1, head_of(32'h100 + 32'(4 * i))}) begin
                errors++;
                $display("FAIL wrap_push_%0d: got %h expected %h", i,
                         {bus.ready_f, bus.valid_d, bus.pcD, bus.pc_plus4D, bus.instrD},
                         {1'b1, head_of(32'h100 + 32'(4 * i))});
            end
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            checks++;
            if ({bus.ready_f, bus.valid_d} !== 2'b10) begin
                errors++;
                $display("FAIL wrap_pop_%0d: got ready_f/valid_d=%b expected 10", i, {bus.ready_f, bus.valid_d});
            end
        end
    endtask

    task automatic test_back_to_back_full();
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            checks++;
            if ({bus.valid_d, bus.pcD} !== {(i == 0), (i == 0) ? 32'h204 : 32'h204}) begin
                errors++;
                $display("FAIL b2b_order_%0d: got %h expected %h", i, {bus.valid_d, bus.pcD},
                         {(i == 0), 32'h204});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_pop_reject();
        test_stream();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_back_to_back_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
